memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/load_extend.sv | 39 +++
 rtl/memory_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V load/store size encodings and memory-stage FSM states
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Funct3[1:0] carries the access size; Funct3[2] selects zero extension.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed byte/half of a read word and sign- or zero-extends it
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_en;

  assign sign_en  = ~funct3_i[2];
  assign half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (offset_i)
      2'b01:   byte_sel = rdata_i[15:8];
      2'b10:   byte_sel = rdata_i[23:16];
      2'b11:   byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
  end

  always_comb begin
    data_o = rdata_i;
    case (funct3_i[1:0])
      SZ_B:    data_o = {{(XLEN-8){sign_en & byte_sel[7]}}, byte_sel};
      SZ_H:    data_o = {{(XLEN-16){sign_en & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline M stage: data-memory handshake FSM, stall, MEM/WB register
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic            RegWriteM,
  input  logic            ResultSrcM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] ALU_ResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            StallM,
  output logic            RegWriteW,
  output logic            ResultSrcW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            MisalignW
`endif
);

  mem_state_t      state_q, state_d;
  logic            mem_op, is_load, misalign;
  logic [1:0]      size, offset;
  logic [XLEN-1:0] load_data;

  logic            reg_write_q, result_src_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_result_q, read_data_q, pc_plus4_q;

  assign size    = Funct3M[1:0];
  assign offset  = ALU_ResultM[1:0];
  assign mem_op  = MemReadM | MemWriteM;
  assign is_load = MemReadM & ~MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign  = mem_op & (((size == SZ_H) & offset[0]) | ((size == SZ_W) & (offset != 2'b00)));
  assign MisalignW = misalign_q;
`else
  assign misalign  = 1'b0;
`endif

  // Address/enables/data come straight from M; StallM freezes M so they stay put while BUSY.
  always_comb begin
    dmem_req = 1'b0;
    if (!rst) begin
      if (state_q == ST_BUSY) dmem_req = 1'b1;
      else                    dmem_req = mem_op & ~misalign;
    end
  end

  assign StallM    = dmem_req & ~dmem_ready;
  assign dmem_we   = MemWriteM;
  assign dmem_addr = {ALU_ResultM[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    case (size)
      SZ_B: begin
        dmem_be    = 4'b0001 << offset;
        dmem_wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        dmem_be    = 4'b0011 << {offset[1], 1'b0};
        dmem_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = WriteDataM;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dmem_req && !dmem_ready) state_d = ST_BUSY;
      ST_BUSY: if (dmem_ready)              state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3_i (Funct3M),
    .offset_i (offset),
    .rdata_i  (dmem_rdata),
    .data_o   (load_data)
  );

  // A stalled cycle still clocks the register, but with writeback suppressed (bubble).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
    end else begin
      state_q      <= state_d;
      reg_write_q  <= RegWriteM & ~StallM & ~misalign;
      result_src_q <= ResultSrcM;
      rd_q         <= RdM;
      alu_result_q <= ALU_ResultM;
      read_data_q  <= (is_load && !misalign) ? load_data : '0;
      pc_plus4_q   <= PCPlus4M;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign;
  end
`endif

  assign RegWriteW   = reg_write_q;
  assign ResultSrcW  = result_src_q;
  assign RdW         = rd_q;
  assign ALU_ResultW = alu_result_q;
  assign ReadDataW   = read_data_q;
  assign PCPlus4W    = pc_plus4_q;

endmodule
